// File: rtl/multicycle_control_fsm.sv
// Multicycle fetch/decode/execute/writeback control unit for the RV32I-subset core.
// Optional macro PERF_COUNTERS_EN adds cycle_cnt / instret_cnt performance counters.
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_write,
  output logic               adr_src,
  output logic               ir_write,
  output logic               pc_write,
  output logic               branch,
  output logic               reg_write,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         result_src,
  output logic [2:0]         alu_control,
  output logic               illegal,
  output logic [STATE_W-1:0] state
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instret_cnt
`endif
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [2:0] F3_BGE = 3'b101;

  typedef enum logic [STATE_W-1:0] {
    BOOT, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, LUI, TRAP
  } state_t;

  state_t     state_reg;
  logic [2:0] alu_f3;
  logic       f3_ok;

  // Only add, sll and and exist in the ALU; everything else is unsupported.
  always_comb begin
    alu_f3 = 3'b000;
    f3_ok  = 1'b1;
    case (funct3)
      3'b000:  alu_f3 = 3'b000;
      3'b001:  alu_f3 = 3'b001;
      3'b111:  alu_f3 = 3'b010;
      default: f3_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= BOOT;
    end else begin
      case (state_reg)
        BOOT:     state_reg <= FETCH;
        FETCH:    if (mem_ready) state_reg <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_reg <= MEMADR;
            OP_R:         state_reg <= EXECR;
            OP_I:         state_reg <= EXECI;
            OP_BR:        state_reg <= BRANCH;
            OP_LUI:       state_reg <= LUI;
            default:      state_reg <= TRAP;
          endcase
        end
        MEMADR: begin
          if (opcode == OP_LW)      state_reg <= MEMREAD;
          else if (opcode == OP_SW) state_reg <= MEMWRITE;
          else                      state_reg <= TRAP;
        end
        MEMREAD:  if (mem_ready) state_reg <= MEMWB;
        MEMWB:    state_reg <= FETCH;
        MEMWRITE: if (mem_ready) state_reg <= FETCH;
        EXECR:    state_reg <= (f3_ok && !funct7b5) ? ALUWB : TRAP;
        EXECI:    state_reg <= f3_ok ? ALUWB : TRAP;
        ALUWB:    state_reg <= FETCH;
        BRANCH:   state_reg <= (funct3 == F3_BGE) ? FETCH : TRAP;
        LUI:      state_reg <= FETCH;
        TRAP:     state_reg <= TRAP;
        default:  state_reg <= TRAP;
      endcase
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = 3'b000;
    illegal     = 1'b0;
    case (state_reg)
      FETCH: begin
        mem_req    = 1'b1;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_f3;
      end
      EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_f3;
      end
      ALUWB: reg_write = 1'b1;
      BRANCH: begin
        // A non-bge branch must not reach the PC-load AND gate.
        if (funct3 == F3_BGE) begin
          alu_src_a   = 2'b10;
          alu_control = 3'b100;
          branch      = 1'b1;
        end
      end
      LUI: begin
        alu_src_b   = 2'b01;
        alu_control = 3'b101;
        result_src  = 2'b10;
        reg_write   = 1'b1;
      end
      TRAP:    illegal = 1'b1;
      default: ;
    endcase
  end

  assign state = state_reg;

`ifdef PERF_COUNTERS_EN
  logic retire;

  // An instruction retires on the edge that returns the FSM to FETCH.
  assign retire = (state_reg == MEMWB) || (state_reg == ALUWB) || (state_reg == LUI) ||
                  ((state_reg == MEMWRITE) && mem_ready) ||
                  ((state_reg == BRANCH) && (funct3 == F3_BGE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      if ((state_reg != BOOT) && (state_reg != TRAP)) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: the driver pushes per-cycle expected
// control words from an instruction-level model; a negedge monitor pops and compares.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        funct7b5 = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, branch, reg_write, illegal;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  alu_control;
  logic [3:0]  state;
`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .branch(branch), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_control(alu_control), .illegal(illegal), .state(state)
`ifdef PERF_COUNTERS_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] w;
    logic [16:0] m;
    logic [31:0] cyc;
    logic [31:0] ins;
  } exp_t;

  localparam int K_I = 0, K_R = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_LUI = 5, K_BAD = 6;
  localparam logic [16:0] FULL   = 17'h1FFFF;
  localparam logic [16:0] NO_ALU = 17'h1FFF1;  // ignore alu_control
  localparam logic [16:0] NO_DP  = 17'h1FC01;  // ignore all datapath selects

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0, errors = 0, ncycle = 0;
  logic [31:0] exp_cyc = 0, exp_ins = 0;
  logic [6:0]  ir_op = 7'd0;
  logic [2:0]  ir_f3 = 3'd0;
  logic        ir_f7 = 1'b0;
  logic [16:0] act;

  assign act = {mem_req, mem_write, adr_src, ir_write, pc_write, branch, reg_write,
                alu_src_a, alu_src_b, result_src, alu_control, illegal};

  function automatic logic [16:0] cw(input logic req, wr, adr, irw, pcw, br, rw,
                                     input logic [1:0] a, b, res, input logic [2:0] alu,
                                     input logic ill);
    return {req, wr, adr, irw, pcw, br, rw, a, b, res, alu, ill};
  endfunction

  wire [16:0] F_WAIT = cw(1,0,0,0,0,0,0, 2'b00, 2'b10, 2'b10, 3'b000, 0);
  wire [16:0] F_GO   = cw(1,0,0,1,1,0,0, 2'b00, 2'b10, 2'b10, 3'b000, 0);
  wire [16:0] DEC    = cw(0,0,0,0,0,0,0, 2'b01, 2'b01, 2'b00, 3'b000, 0);
  wire [16:0] MADR   = cw(0,0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 3'b000, 0);
  wire [16:0] MRD    = cw(1,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
  wire [16:0] MWB    = cw(0,0,0,0,0,0,1, 2'b00, 2'b00, 2'b01, 3'b000, 0);
  wire [16:0] MWR    = cw(1,1,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
  wire [16:0] AWB    = cw(0,0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 0);
  wire [16:0] BGE    = cw(0,0,0,0,0,1,0, 2'b10, 2'b00, 2'b00, 3'b100, 0);
  wire [16:0] LUIW   = cw(0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b10, 3'b101, 0);
  wire [16:0] TRAPW  = cw(0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 1);

  always @(negedge clk) begin
    ncycle++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (((act ^ mon_e.w) & mon_e.m) != 17'd0) begin
        errors++;
        $display("FAIL ctrl cycle %0d: got %05h required %05h (mask %05h)",
                 ncycle, act, mon_e.w, mon_e.m);
      end
`ifdef PERF_COUNTERS_EN
      checks++;
      if (cycle_cnt != mon_e.cyc || instret_cnt != mon_e.ins) begin
        errors++;
        $display("FAIL perf cycle %0d: got cyc=%0d ins=%0d required cyc=%0d ins=%0d",
                 ncycle, cycle_cnt, instret_cnt, mon_e.cyc, mon_e.ins);
      end
`endif
    end
    checks++;
    if ((32'(reg_write) + 32'(mem_write) + 32'(pc_write)) > 32'd1) begin
      errors++;
      $display("FAIL we_exclusive cycle %0d: got rw=%b mw=%b pw=%b required at most one",
               ncycle, reg_write, mem_write, pc_write);
    end
  end

  task automatic push(input logic [16:0] w, input logic [16:0] m, input bit cnt, input bit ret);
    exp_t e;
    e.w = w; e.m = m; e.cyc = exp_cyc; e.ins = exp_ins;
    exp_q.push_back(e);
    if (cnt) exp_cyc++;
    if (ret) exp_ins++;
  endtask

  // One clock cycle: new IR fields take effect only after the previous instruction's last edge.
  task automatic step(input logic rdy, input logic [16:0] w, input logic [16:0] m,
                      input bit cnt, input bit ret);
    @(posedge clk); #1;
    opcode = ir_op; funct3 = ir_f3; funct7b5 = ir_f7;
    mem_ready = rdy;
    push(w, m, cnt, ret);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst_n = 1'b0;
      mem_ready = 1'($urandom);
      exp_cyc = 0; exp_ins = 0;
      push(17'd0, FULL, 0, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    push(17'd0, FULL, 0, 0);
  endtask

  function automatic logic [6:0] op_of(input int kind);
    logic [6:0] bad [5] = '{7'b1101111, 7'b0010111, 7'b1100111, 7'b1110011, 7'b0000000};
    case (kind)
      K_I:     return 7'b0010011;
      K_R:     return 7'b0110011;
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      K_BR:    return 7'b1100011;
      K_LUI:   return 7'b0110111;
      default: return bad[$urandom_range(0, 4)];
    endcase
  endfunction

  task automatic fetch_decode(input int fw);
    for (int i = 0; i < fw; i++) step(1'b0, F_WAIT, FULL, 1, 0);
    step(1'b1, F_GO, FULL, 1, 0);
    step(1'($urandom), DEC, FULL, 1, 0);
  endtask

  task automatic run_instr(input int kind, input logic [2:0] f3, input logic f7,
                           input int fw, input int mw);
    bit          trap;
    bit          f3_ok;
    logic [2:0]  alu;
    logic [16:0] w;
    trap  = 0;
    f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b111);
    alu   = (f3 == 3'b001) ? 3'b001 : (f3 == 3'b111) ? 3'b010 : 3'b000;
    ir_op = op_of(kind); ir_f3 = f3; ir_f7 = f7;
    fetch_decode(fw);
    case (kind)
      K_I, K_R: begin
        w = cw(0,0,0,0,0,0,0, 2'b10, (kind == K_I) ? 2'b01 : 2'b00, 2'b00, alu, 0);
        if (f3_ok && !(kind == K_R && f7)) begin
          step(1'($urandom), w, FULL, 1, 0);
          step(1'($urandom), AWB, FULL, 1, 1);
        end else begin
          step(1'($urandom), w, NO_ALU, 1, 0);
          trap = 1;
        end
      end
      K_LW: begin
        step(1'($urandom), MADR, FULL, 1, 0);
        for (int i = 0; i < mw; i++) step(1'b0, MRD, FULL, 1, 0);
        step(1'b1, MRD, FULL, 1, 0);
        step(1'($urandom), MWB, FULL, 1, 1);
      end
      K_SW: begin
        step(1'($urandom), MADR, FULL, 1, 0);
        for (int i = 0; i < mw; i++) step(1'b0, MWR, FULL, 1, 0);
        step(1'b1, MWR, FULL, 1, 1);
      end
      K_BR: begin
        if (f3 == 3'b101) begin
          step(1'($urandom), BGE, FULL, 1, 1);
        end else begin
          step(1'($urandom), 17'd0, NO_DP, 1, 0);
          trap = 1;
        end
      end
      K_LUI: step(1'($urandom), LUIW, FULL, 1, 1);
      default: trap = 1;
    endcase
    if (trap) begin
      // illegal stays set whatever the instruction inputs do afterwards
      for (int i = 0; i < 3; i++) begin
        ir_op = 7'($urandom); ir_f3 = 3'($urandom); ir_f7 = 1'($urandom);
        step(1'($urandom), TRAPW, FULL, 0, 0);
      end
      do_reset(1 + $urandom_range(0, 1));
    end
  endtask

  initial begin
    int          kind;
    logic [2:0]  f3;
    logic        f7;
    logic [2:0]  legal_f3 [3] = '{3'b000, 3'b001, 3'b111};

    do_reset(2);
    run_instr(K_I,   3'b000, 1'b0, 0, 0);   // addi, zero wait
    run_instr(K_LW,  3'b010, 1'b0, 0, 2);   // lw, two MEMREAD wait states
    run_instr(K_BR,  3'b101, 1'b0, 0, 0);   // bge
    run_instr(K_LUI, 3'b000, 1'b0, 1, 0);
    run_instr(K_SW,  3'b010, 1'b0, 2, 1);
    run_instr(K_R,   3'b111, 1'b0, 0, 0);   // and
    run_instr(K_I,   3'b001, 1'b0, 0, 0);   // slli
    run_instr(K_BR,  3'b001, 1'b0, 0, 0);   // bne -> trap
    run_instr(K_R,   3'b000, 1'b1, 0, 0);   // sub -> trap
    run_instr(K_I,   3'b000, 1'b0, 0, 0);
    run_instr(K_SW,  3'b010, 1'b0, 0, 0);
    run_instr(K_LW,  3'b010, 1'b0, 0, 0);

    // Reset during a MEMWRITE wait state: mem_req must fall without a clock edge.
    ir_op = 7'b0100011; ir_f3 = 3'b010; ir_f7 = 1'b0;
    fetch_decode(0);
    step(1'($urandom), MADR, FULL, 1, 0);
    step(1'b0, MWR, FULL, 1, 0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL memwrite_hold: got mem_req=%b required 1", mem_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_req: got mem_req=%b required 0", mem_req);
    end
    exp_cyc = 0; exp_ins = 0;
    push(17'd0, FULL, 0, 0);
    do_reset(1);

    for (int n = 0; n < 120; n++) begin
      kind = $urandom_range(0, 6);
      f3   = 3'($urandom);
      f7   = 1'b0;
      if (kind == K_I || kind == K_R) begin
        if ($urandom_range(0, 3) != 0) f3 = legal_f3[$urandom_range(0, 2)];
        if (kind == K_I || $urandom_range(0, 5) == 0) f7 = 1'($urandom);
      end else if (kind == K_BR && $urandom_range(0, 3) != 0) begin
        f3 = 3'b101;
      end
      run_instr(kind, f3, f7, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
